mem_store_align: RTL and testbench

// - MEM-stage store path of the 5-stage pipeline; write-side counterpart of the load extender.
// - Narrows sb/sh/sw store data onto the 32-bit data-memory bus: lane replication plus 4-bit byte enables.
// - Drives a req/ack write handshake to data memory and stalls the pipeline until the write completes or times out.

---
 rtl/mem_store_align.sv | 180 ++++++++++++++++++
 tb/tb_mem_store_align.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_align.sv
// mem_store_align: MEM-stage store path of the 5-stage pipeline.
// - Narrows sb/sh/sw data onto the 32-bit data bus (lane replication and byte enables).
// - Runs a req/ack write handshake and stalls the pipeline while a write is in flight.
// - A write that sees no ack within TIMEOUT cycles is abandoned with a bus-error pulse
//   (TIMEOUT = 0 waits forever).
// - Optional macro STORE_MISALIGN_TRAP_EN: misaligned half/word stores are rejected with
//   o_Misalign_Exc. Without it, the low address bits are truncated to natural alignment.
module mem_store_align #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Valid,
    input  logic [31:0] i_Addr,
    input  logic [31:0] i_Data,
    input  logic [1:0]  i_Size,
    output logic        o_Ready,
    output logic        o_Stall,
    output logic        o_Mem_Req,
    output logic [31:0] o_Mem_Addr,
    output logic [31:0] o_Mem_WData,
    output logic [3:0]  o_Mem_BE,
    input  logic        i_Mem_Ack,
    output logic        o_Done,
    output logic        o_Bus_Err,
    output logic        o_Misalign_Exc
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             req_r;
    logic             req_s;
    logic             done_r;
    logic             done_s;
    logic             err_r;
    logic             err_s;
    logic             exc_r;
    logic             exc_s;
    logic             load_s;
    logic             misalign_s;
    logic [31:0]      addr_r;
    logic [31:0]      wdata_r;
    logic [3:0]       be_r;

    // Byte enables for a store of the given size at the given low address bits.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   lane_be = 4'b0001 << addr_lo;
            2'b01:   lane_be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    // Store data replicated across every lane the size can land in.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   lane_wdata = {4{data[7:0]}};
            2'b01:   lane_wdata = {2{data[15:0]}};
            default: lane_wdata = data;
        endcase
    endfunction

`ifdef STORE_MISALIGN_TRAP_EN
    // Flag half stores on odd addresses and word stores off a word boundary.
    always_comb begin
        misalign_s = 1'b0;
        if (i_Size == 2'b01) begin
            misalign_s = i_Addr[0];
        end else if (i_Size[1]) begin
            misalign_s = (i_Addr[1:0] != 2'b00);
        end else begin
            misalign_s = 1'b0;
        end
    end
`else
    assign misalign_s = 1'b0;
`endif

    // Next-state and next-pulse logic for the IDLE/REQ handshake.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        req_s   = 1'b0;
        done_s  = 1'b0;
        err_s   = 1'b0;
        exc_s   = 1'b0;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_Valid && misalign_s) begin
                    exc_s = 1'b1;
                end else if (i_Valid) begin
                    load_s  = 1'b1;
                    state_s = ST_REQ;
                    req_s   = 1'b1;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (i_Mem_Ack) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b1;
                end else begin
                    req_s = 1'b1;
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, timeout counter and handshake/pulse output registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            req_r   <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            exc_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            req_r   <= req_s;
            done_r  <= done_s;
            err_r   <= err_s;
            exc_r   <= exc_s;
        end
    end

    // Bus address/data/enables captured at accept and held for the whole request.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            be_r    <= 4'b0000;
        end else if (load_s) begin
            addr_r  <= {i_Addr[31:2], 2'b00};
            wdata_r <= lane_wdata(i_Size, i_Data);
            be_r    <= lane_be(i_Size, i_Addr[1:0]);
        end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            be_r    <= be_r;
        end
    end

    assign o_Ready     = (state_r == ST_IDLE);
    assign o_Stall     = (state_r != ST_IDLE) | (i_Valid & o_Ready);
    assign o_Mem_Req   = req_r;
    assign o_Mem_Addr  = addr_r;
    assign o_Mem_WData = wdata_r;
    assign o_Mem_BE    = be_r;
    assign o_Done      = done_r;
    assign o_Bus_Err   = err_r;
`ifdef STORE_MISALIGN_TRAP_EN
    assign o_Misalign_Exc = exc_r;
`else
    assign o_Misalign_Exc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_store_align.sv
// Directed testbench for mem_store_align (TIMEOUT = 16). Honours STORE_MISALIGN_TRAP_EN.
module tb_mem_store_align;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        ready;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        done;
    logic        bus_err;
    logic        misalign_exc;

    int tests_run;
    int tests_failed;

    mem_store_align #(.TIMEOUT(16)) dut (
        .i_Clk          (clk),
        .i_Rst_n        (rst_n),
        .i_Valid        (valid),
        .i_Addr         (addr),
        .i_Data         (data),
        .i_Size         (size),
        .o_Ready        (ready),
        .o_Stall        (stall),
        .o_Mem_Req      (mem_req),
        .o_Mem_Addr     (mem_addr),
        .o_Mem_WData    (mem_wdata),
        .o_Mem_BE       (mem_be),
        .i_Mem_Ack      (mem_ack),
        .o_Done         (done),
        .o_Bus_Err      (bus_err),
        .o_Misalign_Exc (misalign_exc)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a store for one edge, then drop i_Valid.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        valid = 1'b1;
        addr  = a;
        data  = d;
        size  = s;
        tick();
        valid = 1'b0;
    endtask

    task automatic ack_and_check_done(input string tag);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_req_off"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        tick();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n   = 1'b0;
        valid   = 1'b0;
        addr    = 32'h0;
        data    = 32'h0;
        size    = 2'b00;
        mem_ack = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, bus_err}, 32'd0);
        check("rst_be", {28'd0, mem_be}, 32'd0);
        rst_n = 1'b1;
        tick();

        // sb to 0x1003
        valid = 1'b1; addr = 32'h0000_1003; data = 32'h0000_00AB; size = 2'b00;
        #1;
        check("sb_stall_accept", {31'd0, stall}, 32'd1);
        tick();
        valid = 1'b0;
        check("sb_req", {31'd0, mem_req}, 32'd1);
        check("sb_addr", mem_addr, 32'h0000_1000);
        check("sb_be", {28'd0, mem_be}, 32'h8);
        check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        check("sb_ready", {31'd0, ready}, 32'd0);
        ack_and_check_done("sb");

        // byte lanes at each offset
        for (int i = 0; i < 4; i++) begin
            logic [3:0] exp_be;
            exp_be = 4'b0001 << i;
            issue(32'h0000_0500 + 32'(i), 32'h0000_0011 * 32'(i + 1), 2'b00);
            check("sb_lane_be", {28'd0, mem_be}, {28'd0, exp_be});
            check("sb_lane_wdata", mem_wdata, {4{8'(8'h11 * (i + 1))}});
            ack_and_check_done("sb_lane");
        end

        // sh to 0x2002 and 0x2000
        issue(32'h0000_2002, 32'h1234_BEEF, 2'b01);
        check("sh_hi_be", {28'd0, mem_be}, 32'hC);
        check("sh_hi_wdata", mem_wdata, 32'hBEEF_BEEF);
        check("sh_hi_addr", mem_addr, 32'h0000_2000);
        ack_and_check_done("sh_hi");
        issue(32'h0000_2000, 32'h0000_C0DE, 2'b01);
        check("sh_lo_be", {28'd0, mem_be}, 32'h3);
        check("sh_lo_wdata", mem_wdata, 32'hC0DE_C0DE);
        ack_and_check_done("sh_lo");

        // sw with ack withheld 5 cycles; a competing request must be ignored
        issue(32'h0000_3000, 32'h1234_5678, 2'b10);
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1; addr = 32'h0000_7777; data = 32'hDEAD_DEAD; size = 2'b00;
            #1;
            check("sw_wait_req", {31'd0, mem_req}, 32'd1);
            check("sw_wait_addr", mem_addr, 32'h0000_3000);
            check("sw_wait_wdata", mem_wdata, 32'h1234_5678);
            check("sw_wait_be", {28'd0, mem_be}, 32'hF);
            check("sw_wait_stall", {31'd0, stall}, 32'd1);
            check("sw_wait_ready", {31'd0, ready}, 32'd0);
            tick();
        end
        valid = 1'b0;
        ack_and_check_done("sw_wait");

        // ack in IDLE is ignored
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_req", {31'd0, mem_req}, 32'd0);
        check("idle_ack_done", {31'd0, done}, 32'd0);
        check("idle_ack_ready", {31'd0, ready}, 32'd1);

        // size 11 as word, no ack -> timeout after 16 REQ cycles
        issue(32'h0000_4000, 32'hCAFE_F00D, 2'b11);
        check("to_be", {28'd0, mem_be}, 32'hF);
        check("to_wdata", mem_wdata, 32'hCAFE_F00D);
        for (int i = 0; i < 16; i++) begin
            check("to_req_held", {31'd0, mem_req}, 32'd1);
            check("to_no_err", {31'd0, bus_err}, 32'd0);
            tick();
        end
        check("to_req_drop", {31'd0, mem_req}, 32'd0);
        check("to_err", {31'd0, bus_err}, 32'd1);
        check("to_ready", {31'd0, ready}, 32'd1);
        check("to_no_done", {31'd0, done}, 32'd0);
        tick();
        check("to_err_pulse", {31'd0, bus_err}, 32'd0);

        // ack on the last REQ cycle beats the timeout
        issue(32'h0000_4100, 32'h0BAD_F00D, 2'b10);
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        check("race_req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("race_done", {31'd0, done}, 32'd1);
        check("race_no_err", {31'd0, bus_err}, 32'd0);
        tick();

        // misaligned word store
        issue(32'h0000_3001, 32'h55AA_55AA, 2'b10);
`ifdef STORE_MISALIGN_TRAP_EN
        check("mis_exc", {31'd0, misalign_exc}, 32'd1);
        check("mis_no_req", {31'd0, mem_req}, 32'd0);
        check("mis_ready", {31'd0, ready}, 32'd1);
        tick();
        check("mis_exc_pulse", {31'd0, misalign_exc}, 32'd0);
        check("mis_still_no_req", {31'd0, mem_req}, 32'd0);
`else
        check("mis_exc_tied", {31'd0, misalign_exc}, 32'd0);
        check("mis_req", {31'd0, mem_req}, 32'd1);
        check("mis_addr", mem_addr, 32'h0000_3000);
        check("mis_be", {28'd0, mem_be}, 32'hF);
        ack_and_check_done("mis");
`endif

        // reset mid-REQ, then a clean sb to 0x0
        issue(32'h0000_6000, 32'hFFFF_0000, 2'b10);
        check("mid_req_on", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_req_off", {31'd0, mem_req}, 32'd0);
        check("mid_ready", {31'd0, ready}, 32'd1);
        tick();
        check("mid_no_done", {31'd0, done}, 32'd0);
        check("mid_no_err", {31'd0, bus_err}, 32'd0);
        rst_n = 1'b1;
        tick();
        issue(32'h0000_0000, 32'h0000_005A, 2'b00);
        check("post_rst_be", {28'd0, mem_be}, 32'h1);
        check("post_rst_wdata", mem_wdata, 32'h5A5A_5A5A);
        check("post_rst_addr", mem_addr, 32'h0000_0000);
        ack_and_check_done("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
